// File: rtl/pslip_accept_arb.sv
// rtl/pslip_accept_arb.sv - pSLIP input-side accept arbiter with round-robin pointer
//
// One instance per switch input. Each scheduling round runs ITERS ARB cycles.
// In each ARB cycle the arbiter samples the grants from the output-side arbiters.
// It accepts one grant, chosen round-robin from ptr, unless it is already matched.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse that begins a round (ignored while busy)
//   gnt_in     in   [N-1:0] grants; bit j = output j grants this input
//   acc        out  [N-1:0] registered one-hot accept
//   acc_valid  out  acc carries a fresh accept this cycle
//   matched    out  input matched in the current round
//   match_idx  out  index of the accepted output, valid while matched
//   ptr        out  round-robin accept pointer
//   busy       out  round in progress
//   done       out  one-cycle pulse at the end of a round
module pslip_accept_arb #(
    parameter int N     = 4,
    parameter int ITERS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N-1:0]         gnt_in,
    output logic [N-1:0]         acc,
    output logic                 acc_valid,
    output logic                 matched,
    output logic [$clog2(N)-1:0] match_idx,
    output logic [$clog2(N)-1:0] ptr,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = $clog2(N);
    localparam int IW = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   iter;
    logic [PW-1:0]   sel_hi, sel_lo, sel;
    logic            sel_hi_found;
    logic            do_accept;
    logic            last_iter;

    // Round-robin pick: the lowest set grant at or above ptr.
    // If no grant is at or above ptr, the pick wraps to the lowest set grant.
    // Scanning downward leaves the lowest matching index in each candidate.
    always_comb begin
        sel_hi       = '0;
        sel_lo       = '0;
        sel_hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (gnt_in[i]) begin
                sel_lo = PW'(i);
                if (i >= int'(ptr)) begin
                    sel_hi       = PW'(i);
                    sel_hi_found = 1'b1;
                end
            end
        end
        sel = sel_hi_found ? sel_hi : sel_lo;
    end

    // Gating on state keeps gnt_in (including X) in IDLE/DONE away from state.
    assign do_accept = (state == ARB) && !matched && (|gnt_in);
    assign last_iter = (iter == IW'(ITERS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARB;
            ARB:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            iter      <= '0;
            acc       <= '0;
            acc_valid <= 1'b0;
            matched   <= 1'b0;
            match_idx <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= '0;
            acc_valid <= 1'b0;
            if (state == IDLE && start) begin
                matched <= 1'b0;
                iter    <= '0;
            end
            if (state == ARB) begin
                iter <= iter + IW'(1);
            end
            if (do_accept) begin
                acc       <= N'(1) << sel;
                acc_valid <= 1'b1;
                matched   <= 1'b1;
                match_idx <= sel;
                // The pointer moves only on first-iteration accepts (pSLIP rule).
                // N is a power of two, so the PW-bit add wraps modulo N.
                if (iter == '0) begin
                    ptr <= sel + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pslip_accept_arb.sv
// tb/tb_pslip_accept_arb.sv - directed self-checking bench for pslip_accept_arb
module tb_pslip_accept_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] gnt_in;
    logic [3:0] acc;
    logic       acc_valid;
    logic       matched;
    logic [1:0] match_idx;
    logic [1:0] ptr;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fails  = 0;

    pslip_accept_arb #(.N(4), .ITERS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .gnt_in    (gnt_in),
        .acc       (acc),
        .acc_valid (acc_valid),
        .matched   (matched),
        .match_idx (match_idx),
        .ptr       (ptr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Full round: g0 in iteration 0, g1 in iteration 1.
    // Checks the accept after each iteration, done/busy, and the final IDLE state.
    task automatic do_round(input string tag, input logic [3:0] g0, input logic [3:0] g1,
                            input logic [3:0] e_acc0, input logic [3:0] e_acc1,
                            input logic e_matched, input logic [1:0] e_idx,
                            input logic [1:0] e_ptr);
        start = 1'b1;
        tick();
        start  = 1'b0;
        gnt_in = g0;
        check({tag, " busy_arb"}, busy, 1'b1);
        tick();
        check({tag, " acc0"}, acc, e_acc0);
        check({tag, " acc_valid0"}, acc_valid, |e_acc0);
        check({tag, " done_early"}, done, 1'b0);
        gnt_in = g1;
        tick();
        check({tag, " acc1"}, acc, e_acc1);
        check({tag, " acc_valid1"}, acc_valid, |e_acc1);
        check({tag, " done"}, done, 1'b1);
        gnt_in = 4'b0000;
        tick();
        check({tag, " done_gone"}, done, 1'b0);
        check({tag, " busy_idle"}, busy, 1'b0);
        check({tag, " matched"}, matched, e_matched);
        if (e_matched) check({tag, " match_idx"}, match_idx, e_idx);
        check({tag, " ptr"}, ptr, e_ptr);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        gnt_in = 4'b0000;
        tick();
        check("rst acc", acc, 4'b0000);
        check("rst acc_valid", acc_valid, 1'b0);
        check("rst matched", matched, 1'b0);
        check("rst ptr", ptr, 2'd0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        rst_n = 1'b1;
        tick();

        // X grants while idle must not disturb anything
        gnt_in = 4'bxxxx;
        tick();
        check("idle_x acc_valid", acc_valid, 1'b0);
        check("idle_x ptr", ptr, 2'd0);
        check("idle_x busy", busy, 1'b0);
        gnt_in = 4'b0000;

        // ptr=0, 1010 -> accept 1, ptr 2; iter1 all grants ignored (already matched)
        do_round("basic", 4'b1010, 4'b1111, 4'b0010, 4'b0000, 1'b1, 2'd1, 2'd2);

        // start held high through the round (ignored while busy), no grants anywhere
        start = 1'b1;
        tick();
        gnt_in = 4'b0000;
        tick();
        check("nogrant acc_valid0", acc_valid, 1'b0);
        check("nogrant busy_mid", busy, 1'b1);
        tick();
        check("nogrant done", done, 1'b1);
        start = 1'b0;
        tick();
        check("nogrant busy_idle", busy, 1'b0);
        check("nogrant done_gone", done, 1'b0);
        check("nogrant matched", matched, 1'b0);
        check("nogrant ptr", ptr, 2'd2);

        // ptr=2, 0100 -> accept 2, ptr 3
        do_round("to3", 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2, 2'd3);
        // ptr=3, 0011 -> wrap to 0, ptr = 0+1 = 1
        do_round("wrap0", 4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0, 2'd1);
        // ptr=1, 0100 -> accept 2, ptr 3
        do_round("back3", 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2, 2'd3);
        // late accept: iter0 none, iter1 0100 -> accept 2 (wrap), ptr stays 3
        do_round("late", 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 2'd3);
        // ptr=3, 1001 -> accept 3, ptr wraps to 0
        do_round("wrap3", 4'b1001, 4'b0000, 4'b1000, 4'b0000, 1'b1, 2'd3, 2'd0);

        // reset mid-ARB while acc_valid is high
        start = 1'b1;
        tick();
        start  = 1'b0;
        gnt_in = 4'b0010;
        tick();
        check("prerst acc_valid", acc_valid, 1'b1);
        check("prerst ptr", ptr, 2'd2);
        rst_n = 1'b0;
        #1;
        check("midrst acc", acc, 4'b0000);
        check("midrst acc_valid", acc_valid, 1'b0);
        check("midrst matched", matched, 1'b0);
        check("midrst match_idx", match_idx, 2'd0);
        check("midrst ptr", ptr, 2'd0);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        gnt_in = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
